// File: rtl/branch_resolve_pipe_pkg.sv
// Shared encodings for the branch resolution pipeline: compare codes, branch op codes,
// the stage-1 payload layout and the branch-condition decode.
package branch_resolve_pipe_pkg;

    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_LT = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JMP  = 3'd6,
        BR_NONE = 3'd7
    } br_op_e;

    typedef struct packed {
        logic [1:0]  cmp_s;
        logic [1:0]  cmp_u;
        logic [2:0]  op;
        logic [31:0] target;
        logic        pred;
    } stage1_t;

    function automatic logic cond_taken(input logic [2:0] op, input logic [1:0] cs,
                                        input logic [1:0] cu);
        logic t;
        t = 1'b0;
        case (op)
            BR_BEQ:  t = (cs == CMP_EQ);
            BR_BNE:  t = (cs != CMP_EQ);
            BR_BLT:  t = (cs == CMP_LT);
            BR_BGE:  t = (cs != CMP_LT);
            BR_BLTU: t = (cu == CMP_LT);
            BR_BGEU: t = (cu != CMP_LT);
            BR_JMP:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational WIDTH-bit comparator producing signed and unsigned EQ/LT/GT codes.
module branch_cmp_core
    import branch_resolve_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       cmp_s,
    output logic [1:0]       cmp_u
);

    logic signed [WIDTH:0] diff_s;
    logic        [WIDTH:0] diff_u;
    logic                  eq, lt_s, lt_u;

    // One extra bit keeps the subtraction exact: the sign (signed) or borrow (unsigned).
    assign diff_s = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    assign diff_u = {1'b0, a} - {1'b0, b};

    assign eq   = (diff_u == '0);
    assign lt_s = (diff_s < 0);
    assign lt_u = diff_u[WIDTH];

    assign cmp_s = eq ? CMP_EQ : (lt_s ? CMP_LT : CMP_GT);
    assign cmp_u = eq ? CMP_EQ : (lt_u ? CMP_LT : CMP_GT);

endmodule

// File: rtl/branch_resolve_pipe.sv
// Pipelined branch resolution: compare, condition decode, target add, mispredict flag,
// valid/ready handshake with flush, and saturating retirement counters.
module branch_resolve_pipe
    import branch_resolve_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       cmp_s,
    output logic [1:0]       cmp_u,
    output logic             taken,
    output logic [31:0]      target,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [1:0]  cmp_s_c, cmp_u_c;
    logic [31:0] target_c;
    logic        adv_p1;

    branch_cmp_core #(.WIDTH(WIDTH)) u_cmp (
        .a     (a),
        .b     (b),
        .cmp_s (cmp_s_c),
        .cmp_u (cmp_u_c)
    );

    assign target_c = pc + imm;
    assign in_ready = adv_p1;

    generate
        if (PIPE == 1) begin : g_pipe1
            logic        vld_p1, taken_p1, mis_p1, taken_c;
            logic [1:0]  cmp_s_p1, cmp_u_p1;
            logic [31:0] target_p1;

            assign taken_c = cond_taken(op, cmp_s_c, cmp_u_c);
            assign adv_p1  = !vld_p1 || out_ready;

            // ---- stage 1: compare, decode and target all land here ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1    <= 1'b0;
                    cmp_s_p1  <= CMP_EQ;
                    cmp_u_p1  <= CMP_EQ;
                    target_p1 <= '0;
                    taken_p1  <= 1'b0;
                    mis_p1    <= 1'b0;
                end else begin
                    if (flush)       vld_p1 <= 1'b0;
                    else if (adv_p1) vld_p1 <= in_valid;
                    if (!flush && adv_p1 && in_valid) begin
                        cmp_s_p1  <= cmp_s_c;
                        cmp_u_p1  <= cmp_u_c;
                        target_p1 <= target_c;
                        taken_p1  <= taken_c;
                        mis_p1    <= taken_c ^ pred_taken;
                    end
                end
            end

            assign out_valid  = vld_p1;
            assign cmp_s      = cmp_s_p1;
            assign cmp_u      = cmp_u_p1;
            assign target     = target_p1;
            assign taken      = taken_p1;
            assign mispredict = mis_p1 && vld_p1;
        end else begin : g_pipe2
            stage1_t     s_p1;
            logic        vld_p1, vld_p2, adv_p2, taken_p2, mis_p2, taken_c1;
            logic [1:0]  cmp_s_p2, cmp_u_p2;
            logic [31:0] target_p2;

            assign adv_p2   = !vld_p2 || out_ready;
            assign adv_p1   = !vld_p1 || adv_p2;
            assign taken_c1 = cond_taken(s_p1.op, s_p1.cmp_s, s_p1.cmp_u);

            // ---- stage 1: compare codes, op, target, prediction ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1 <= 1'b0;
                end else if (flush) begin
                    vld_p1 <= 1'b0;
                end else if (adv_p1) begin
                    vld_p1 <= in_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst && !flush && adv_p1 && in_valid) begin
                    s_p1 <= '{cmp_s: cmp_s_c, cmp_u: cmp_u_c, op: op,
                              target: target_c, pred: pred_taken};
                end
            end

            // ---- stage 2: resolved direction and mispredict ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p2    <= 1'b0;
                    cmp_s_p2  <= CMP_EQ;
                    cmp_u_p2  <= CMP_EQ;
                    target_p2 <= '0;
                    taken_p2  <= 1'b0;
                    mis_p2    <= 1'b0;
                end else begin
                    if (flush)       vld_p2 <= 1'b0;
                    else if (adv_p2) vld_p2 <= vld_p1;
                    if (!flush && adv_p2 && vld_p1) begin
                        cmp_s_p2  <= s_p1.cmp_s;
                        cmp_u_p2  <= s_p1.cmp_u;
                        target_p2 <= s_p1.target;
                        taken_p2  <= taken_c1;
                        mis_p2    <= taken_c1 ^ s_p1.pred;
                    end
                end
            end

            assign out_valid  = vld_p2;
            assign cmp_s      = cmp_s_p2;
            assign cmp_u      = cmp_u_p2;
            assign target     = target_p2;
            assign taken      = taken_p2;
            assign mispredict = mis_p2 && vld_p2;
        end
    endgenerate

    // A retiring entry still counts when a flush lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (out_valid && out_ready) begin
            br_count <= sat_inc(br_count);
            if (mispredict) mis_count <= sat_inc(mis_count);
        end
    end

endmodule
